step_seg_feeder: RTL and testbench

- Supplies motion segments to the acceleration step generator, acting as the initiator side of its dt_val/steps_val/load/done handshake.
- Buffers host-written segments in a small synchronous FIFO.
- Issues load at start and on each done, detects starvation and abort, and tracks absolute position from step strobes.
- Sits between the host register/command interface and one step-generator axis.

---
 rtl/step_pkg.sv | 24 ++
 rtl/seg_fifo.sv | 55 +++++
 rtl/step_seg_feeder.sv | 135 +++++++++++++
 tb/tb_step_seg_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the step segment feeder: FSM encoding and the
// packed segment layout {dir, steps, dt} carried through the FIFO.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STARVED = 2'd2
  } state_e;

  localparam int SEG_W     = 65;
  localparam int DT_LSB    = 0;
  localparam int DT_MSB    = 31;
  localparam int STEPS_LSB = 32;
  localparam int STEPS_MSB = 63;
  localparam int DIR_BIT   = 64;

  function automatic logic [SEG_W-1:0] pack_seg(input logic        dir,
                                                input logic [31:0] steps,
                                                input logic [31:0] dt);
    return {dir, steps, dt};
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous show-ahead FIFO. Full/empty are judged on the registered count,
// so a same-cycle pop never frees room for a push and vice versa.
module seg_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int SEG_W = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [SEG_W-1:0] din,
  output logic [SEG_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [SEG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  // DEPTH is a power of two, so the MSB alone marks count == DEPTH
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (flush) begin
        // Discard contents by catching the read side up to the write side
        rd_ptr_q <= wr_ptr_q;
        count_q  <= (AW+1)'(push_ok);
      end else begin
        if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
    end
  end

endmodule

// File: rtl/step_seg_feeder.sv
// Feeds buffered motion segments to one step-generator axis: issues load on
// start/done, handles starvation, tracks signed position and abort steps.
module step_seg_feeder
  import step_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int UCW   = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    wr_dt,
  input  logic [31:0]    wr_steps,
  input  logic           wr_dir,
  input  logic           wr_stb,
  input  logic           flush,
  input  logic           start,
  input  logic           stop,
  input  logic           gen_done,
  input  logic           gen_step_stb,
  input  logic           gen_abort,
  output logic [31:0]    dt_val,
  output logic [31:0]    steps_val,
  output logic           dir,
  output logic           load,
  output logic           full,
  output logic [AW:0]    count,
  output logic           running,
  output logic           overflow,
  output logic           underrun,
  output logic [UCW-1:0] underrun_cnt,
  output logic [31:0]    position
);

  state_e           state_q, state_d;
  logic [31:0]      dt_q, steps_q, pos_q;
  logic             dir_q, load_q, run_q, ovf_q, und_q;
  logic [UCW-1:0]   ucnt_q;
  logic             pop, fl, empty;
  logic [SEG_W-1:0] seg_in, seg_head;

  assign seg_in = pack_seg(wr_dir, wr_steps, wr_dt);

  seg_fifo #(.DEPTH(DEPTH), .AW(AW), .SEG_W(SEG_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_stb),
    .pop   (pop),
    .flush (fl),
    .din   (seg_in),
    .dout  (seg_head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // stop outranks any pop; flush only acts in IDLE when nothing is popped
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fl      = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !empty) begin
            pop     = 1'b1;
            state_d = ST_RUN;
          end else if (flush) begin
            fl = 1'b1;
          end
        end
        ST_RUN: begin
          if (gen_done) begin
            if (!empty) pop = 1'b1;
            else        state_d = ST_STARVED;
          end
        end
        ST_STARVED: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dt_q    <= '0;
      steps_q <= '0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
      ucnt_q  <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d != ST_IDLE);
      load_q  <= pop;
      // Segment outputs only move on a pop; the generator compares them live
      if (pop) begin
        dt_q    <= seg_head[DT_MSB:DT_LSB];
        steps_q <= seg_head[STEPS_MSB:STEPS_LSB];
        dir_q   <= seg_head[DIR_BIT];
      end
      if (wr_stb && full) ovf_q <= 1'b1;
      if (gen_step_stb) begin
        if (gen_abort) begin
          und_q <= 1'b1;
          if (ucnt_q != '1) ucnt_q <= ucnt_q + UCW'(1);
        end else begin
          pos_q <= dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
        end
      end
    end
  end

  assign dt_val       = dt_q;
  assign steps_val    = steps_q;
  assign dir          = dir_q;
  assign load         = load_q;
  assign running      = run_q;
  assign overflow     = ovf_q;
  assign underrun     = und_q;
  assign underrun_cnt = ucnt_q;
  assign position     = pos_q;

endmodule

// File: tb/tb_step_seg_feeder.sv
// Bench for step_seg_feeder: queue-based reference model checked every cycle,
// a behavioural step-generator driving the done/step/abort side, plus directed cases.
module tb_step_seg_feeder;
  localparam int DEPTH = 16, AW = 4, UCW = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] wr_dt = '0, wr_steps = '0;
  logic wr_dir = 0, wr_stb = 0, flush = 0, start = 0, stop = 0;
  logic gen_done = 0, gen_step_stb = 0, gen_abort = 0;
  logic [31:0] dt_val, steps_val, position;
  logic dir, load, full, running, overflow, underrun;
  logic [AW:0] count;
  logic [UCW-1:0] underrun_cnt;

  step_seg_feeder #(.DEPTH(DEPTH), .AW(AW), .UCW(UCW)) dut (
    .clk(clk), .reset(reset), .wr_dt(wr_dt), .wr_steps(wr_steps), .wr_dir(wr_dir),
    .wr_stb(wr_stb), .flush(flush), .start(start), .stop(stop), .gen_done(gen_done),
    .gen_step_stb(gen_step_stb), .gen_abort(gen_abort), .dt_val(dt_val),
    .steps_val(steps_val), .dir(dir), .load(load), .full(full), .count(count),
    .running(running), .overflow(overflow), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .position(position));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  function void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Reference model: segment queue plus mode (0 idle, 1 feeding, 2 starved)
  logic [64:0] mq[$];
  int m_mode;
  logic [31:0] m_dt, m_steps, m_pos;
  logic m_dir, m_load, m_run, m_ovf, m_und;
  logic [UCW-1:0] m_ucnt;

  function void model_step();
    bit empty0, full0, do_pop, do_fl;
    logic [64:0] seg;
    if (reset) begin
      mq.delete(); m_mode = 0; m_dt = 0; m_steps = 0; m_pos = 0; m_dir = 0;
      m_load = 0; m_run = 0; m_ovf = 0; m_und = 0; m_ucnt = 0;
      return;
    end
    empty0 = (mq.size() == 0); full0 = (mq.size() == DEPTH);
    do_pop = 0; do_fl = 0;
    if (stop) m_mode = 0;
    else if (m_mode == 0) begin
      if (start && !empty0) begin do_pop = 1; m_mode = 1; end
      else if (flush) do_fl = 1;
    end else if (m_mode == 1) begin
      if (gen_done) begin if (!empty0) do_pop = 1; else m_mode = 2; end
    end else if (!empty0) begin do_pop = 1; m_mode = 1; end
    if (gen_step_stb && !gen_abort) m_pos = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
    if (gen_step_stb && gen_abort) begin
      m_und = 1;
      if (m_ucnt != '1) m_ucnt = m_ucnt + 1'b1;
    end
    m_load = do_pop;
    if (do_pop) begin
      seg = mq.pop_front();
      m_dir = seg[64]; m_steps = seg[63:32]; m_dt = seg[31:0];
    end
    if (do_fl) mq.delete();
    if (wr_stb) begin
      if (full0) m_ovf = 1;
      else mq.push_back({wr_dir, wr_steps, wr_dt});
    end
    m_run = (m_mode != 0);
  endfunction

  function void check_all();
    chk("dt_val", dt_val, m_dt);
    chk("steps_val", steps_val, m_steps);
    chk("dir", dir, m_dir);
    chk("load", load, m_load);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("running", running, m_run);
    chk("overflow", overflow, m_ovf);
    chk("underrun", underrun, m_und);
    chk("underrun_cnt", underrun_cnt, m_ucnt);
    chk("position", position, m_pos);
  endfunction

  // Generator model: steps every dt clocks, done after the last step, one
  // cycle of grace for a reload, then abort steps until a load arrives.
  int gst = 0, g_dt = 1, g_left = 0, g_tmr = 0, g_aborts = 0;
  function void gen_update();
    gen_done = 0; gen_step_stb = 0; gen_abort = 0;
    if (reset) begin gst = 0; return; end
    if (load) begin
      g_dt = (dt_val == 0) ? 1 : int'(dt_val);
      g_left = int'(steps_val); g_tmr = g_dt; gst = 1;
    end
    case (gst)
      1: if (g_left == 0) begin gen_done = 1; gst = 2; end
         else if (g_tmr <= 1) begin gen_step_stb = 1; g_left--; g_tmr = g_dt; end
         else g_tmr--;
      2: begin gst = 3; g_tmr = g_dt; end
      3: if (g_tmr <= 1) begin gen_step_stb = 1; gen_abort = 1; g_aborts++; g_tmr = g_dt; end
         else g_tmr--;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); model_step();
    @(negedge clk); check_all();
    wr_stb = 0; start = 0; stop = 0; flush = 0;
    gen_update();
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] s, input logic dr);
    wr_dt = d; wr_steps = s; wr_dir = dr; wr_stb = 1; tick();
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  typedef struct {
    bit wr, st, sp, fl;
    logic [31:0] dt;
    int e_count;
    bit e_run, e_load;
    logic [31:0] e_dt;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nl, nd;
    bit trig, saw99;
    logic [31:0] prev_dt;

    // Reset state
    do_reset();
    chk("rst_count", count, 0); chk("rst_load", load, 0);
    chk("rst_running", running, 0); chk("rst_position", position, 0);

    // Sequencing: three segments, load one cycle after start/done
    push(4, 2, 1); push(3, 1, 0); push(2, 3, 1);
    start = 1; nl = 0; nd = 0; n = 0; prev_dt = dt_val;
    while (nd < 3 && n < 200) begin
      trig = start | gen_done;
      if (gen_done) nd++;
      tick(); n++;
      if (load) begin nl++; chk("seq_load_latency", trig, 1); end
      else chk("seq_dt_stable", dt_val, prev_dt);
      prev_dt = dt_val;
    end
    chk("seq_timeout", n < 200, 1);
    chk("seq_loads", nl, 3); chk("seq_position", position, 4);
    chk("seq_starved_running", running, 1); chk("seq_starved_noload", load, 0);

    // Underrun and recovery
    do_reset(); g_aborts = 0;
    push(2, 1, 1); start = 1; tick();
    n = 0;
    while (g_aborts < 3 && n < 300) begin tick(); n++; end
    chk("und_timeout", n < 300, 1);
    push(2, 2, 1);
    chk("und_flag", underrun, 1); chk("und_cnt", underrun_cnt, 3);
    chk("und_pos_held", position, 1);
    tick();
    chk("und_reload", load, 1); chk("und_running", running, 1);
    n = 0;
    while (position != 3 && n < 100) begin tick(); n++; end
    chk("und_final_pos", position, 3);

    // Full and overflow
    do_reset();
    for (int i = 0; i < 16; i++) push(32'(i + 1), 0, 1);
    chk("full_flag", full, 1); chk("full_count", count, 16); chk("full_noovf", overflow, 0);
    push(99, 0, 1);
    chk("ovf_flag", overflow, 1); chk("ovf_count", count, 16);
    start = 1; nl = 0; saw99 = 0; n = 0;
    while (!(nl == 16 && gst == 3) && n < 400) begin
      tick(); n++;
      if (load) begin nl++; if (dt_val == 99) saw99 = 1; end
    end
    chk("ovf_loads", nl, 16); chk("ovf_dropped_never_loaded", saw99, 0);

    // Simultaneous push and pop
    do_reset();
    push(1, 1, 1); push(2, 2, 0); start = 1; tick();
    chk("sim_count1", count, 1);
    n = 0;
    while (!gen_done && n < 50) begin tick(); n++; end
    push(3, 1, 1);
    chk("sim_load", load, 1); chk("sim_dt_old_head", dt_val, 2); chk("sim_count", count, 1);
    n = 0;
    while (!gen_done && n < 50) begin tick(); n++; end
    tick();
    chk("sim_next_load", load, 1); chk("sim_dt_new", dt_val, 3);

    // Stop / flush / ignored start, table-driven
    do_reset();
    vecs[0] = '{1, 0, 0, 0, 5, 1, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 6, 2, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 1, 1, 1, 5};
    vecs[3] = '{0, 0, 1, 0, 0, 1, 0, 0, 5};
    vecs[4] = '{0, 1, 1, 0, 0, 1, 0, 0, 5};
    vecs[5] = '{0, 0, 0, 1, 0, 0, 0, 0, 5};
    vecs[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 5};
    vecs[7] = '{1, 0, 0, 0, 7, 1, 0, 0, 5};
    vecs[8] = '{0, 1, 0, 0, 0, 0, 1, 1, 7};
    for (int i = 0; i < 9; i++) begin
      wr_stb = vecs[i].wr; wr_dt = vecs[i].dt; wr_steps = 9; wr_dir = 1;
      start = vecs[i].st; stop = vecs[i].sp; flush = vecs[i].fl;
      tick();
      chk("vec_count", count, vecs[i].e_count);
      chk("vec_running", running, vecs[i].e_run);
      chk("vec_load", load, vecs[i].e_load);
      chk("vec_dt", dt_val, vecs[i].e_dt);
    end

    // Negative wrap from 0
    do_reset();
    push(1, 1, 0); start = 1; tick();
    n = 0;
    while (position == 0 && n < 20) begin tick(); n++; end
    chk("wrap_position", position, 32'hFFFF_FFFF);

    // Reset mid-run with count=5
    do_reset();
    for (int i = 0; i < 6; i++) push(2, 3, 1);
    start = 1; tick();
    chk("mid_count5", count, 5); chk("mid_running", running, 1);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_count", count, 0); chk("mid_rst_running", running, 0);
    chk("mid_rst_dt", dt_val, 0); chk("mid_rst_steps", steps_val, 0);
    chk("mid_rst_load", load, 0); chk("mid_rst_pos", position, 0);
    push(3, 1, 1); start = 1; tick();
    chk("post_rst_load", load, 1); chk("post_rst_dt", dt_val, 3);
    chk("post_rst_count", count, 0); chk("post_rst_running", running, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      wr_stb = ($urandom_range(2) == 0);
      wr_dt = $urandom_range(4); wr_steps = $urandom_range(3); wr_dir = 1'($urandom_range(1));
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(63) == 0);
      flush = ($urandom_range(15) == 0);
      reset = ($urandom_range(499) == 0);
      tick();
      reset = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
